// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-command-at-a-time ALU sequencer with accumulator; optional SEQ_FLAGS_EN adds flag_z/flag_n
module alu_op_sequencer #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
`ifdef SEQ_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n
`endif
);

  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] acc_next;

  // nop and illegal ops leave the accumulator untouched
  always_comb begin
    acc_next = acc;
    if (op_q <= OP_INC) acc_next = alu_result;
  end

  assign cmd_ready = !rst && (state == IDLE);
  assign alu_a     = acc;
  assign alu_b     = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      data_q    <= '0;
      acc       <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      alu_sel   <= OP_NOP;
`ifdef SEQ_FLAGS_EN
      flag_z    <= 1'b1;
      flag_n    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            alu_sel <= cmd_op;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          acc       <= acc_next;
          rsp_data  <= acc_next;
          rsp_err   <= (op_q == OP_ILL);
          rsp_valid <= 1'b1;
          alu_sel   <= OP_NOP;
`ifdef SEQ_FLAGS_EN
          flag_z    <= (acc_next == '0);
          flag_n    <= acc_next[WIDTH-1];
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
